// File: rtl/nx_ram_fifo_pkg.sv
// Shared sizing helpers and parameter legality check for the RAM-backed FWFT FIFO controller.
package nx_ram_fifo_pkg;

    function automatic int unsigned calc_lat(input int unsigned rd_latency,
                                             input int unsigned out_flop);
        return rd_latency + out_flop;
    endfunction

    function automatic int unsigned calc_aw(input int unsigned depth);
        return unsigned'($clog2(depth));
    endfunction

    function automatic int unsigned calc_cw(input int unsigned depth,
                                            input int unsigned pf_depth);
        return unsigned'($clog2(depth + pf_depth + 1));
    endfunction

    function automatic logic params_ok(input int unsigned depth,
                                       input int unsigned rd_latency,
                                       input int unsigned out_flop,
                                       input int unsigned pf_depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0) && (rd_latency >= 1) &&
               (out_flop <= 1) && (pf_depth >= rd_latency + out_flop + 1);
    endfunction

endpackage

// File: rtl/nx_ram_fifo_pf_buf.sv
// Circular prefetch buffer holding RAM read data; head word is muxed combinationally.
module nx_ram_fifo_pf_buf #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
    logic [CW-1:0]    r_cnt;
    logic             w_rd;

    assign w_rd     = i_rd && (r_cnt != '0);
    assign w_wr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
    assign o_rdata  = r_mem[r_rd_ptr];
    assign o_count  = r_cnt;

    // When full, a same-cycle fill lands on the slot being popped; the head was already consumed.
    always_ff @(posedge i_clk) begin
        if (i_wr && !i_clr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_wr) r_wr_ptr <= w_wr_nxt;
            if (w_rd) r_rd_ptr <= w_rd_nxt;
            if (i_wr && !w_rd) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!i_wr && w_rd) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nx_ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller on a 1R1W RAM macro with a latency-hiding prefetch buffer.
module nx_ram_fifo_ctrl
    import nx_ram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned OUT_FLOP   = 0,
    parameter int unsigned PF_DEPTH   = RD_LATENCY + OUT_FLOP + 1,
    localparam int unsigned AW = calc_aw(DEPTH),
    localparam int unsigned CW = calc_cw(DEPTH, PF_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [CW-1:0]    o_count,
    output logic             o_ram_web,
    output logic [AW-1:0]    o_ram_wa,
    output logic [WIDTH-1:0] o_ram_din,
    output logic [WIDTH-1:0] o_ram_bwe,
    output logic             o_ram_reb,
    output logic [AW-1:0]    o_ram_ra,
    input  logic [WIDTH-1:0] i_ram_dout
);

    localparam int unsigned L   = calc_lat(RD_LATENCY, OUT_FLOP);
    localparam int unsigned PCW = $clog2(PF_DEPTH + 1);
    localparam int unsigned IW  = $clog2(L + 1);

    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_ram_cnt, w_ram_cnt_d;
    logic [L-1:0]     r_flag, r_drop, w_flag_d, w_drop_d, w_live;
    logic [IW-1:0]    w_inflight, w_inflight_d;
    logic [PCW-1:0]   w_pf_cnt, w_pf_cnt_d;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_pf_data;
    logic             w_in_ready, w_out_valid, w_push, w_pop, w_issue, w_fill, w_pf_room;

    assign w_in_ready  = i_rst_n && !i_clr && (r_ram_cnt < (AW + 1)'(DEPTH));
    assign w_push      = i_in_valid && w_in_ready;
    assign w_out_valid = (w_pf_cnt != '0) && !i_clr;
    assign w_pop       = w_out_valid && i_out_ready;
    assign w_live      = r_flag & ~r_drop;
    assign w_fill      = w_live[L-1] && !i_clr;

    // Reserve a prefetch slot for every live read so returning data can never overflow it.
    assign w_pf_room = (CW'(w_pf_cnt) + CW'(w_inflight) - CW'(w_pop)) < CW'(PF_DEPTH);
    assign w_issue   = i_rst_n && !i_clr && (r_ram_cnt != '0) && w_pf_room;

    always_comb begin
        w_inflight = '0;
        for (int unsigned k = 0; k < L; k++) begin
            w_inflight = w_inflight + IW'(w_live[k]);
        end
    end

    always_comb begin
        w_flag_d    = '0;
        w_drop_d    = '0;
        w_flag_d[0] = w_issue;
        for (int unsigned k = 1; k < L; k++) begin
            w_flag_d[k] = r_flag[k-1];
            w_drop_d[k] = r_drop[k-1] | i_clr;
        end
        w_inflight_d = '0;
        for (int unsigned k = 0; k < L; k++) begin
            w_inflight_d = w_inflight_d + IW'(w_flag_d[k] & ~w_drop_d[k]);
        end

        w_ram_cnt_d = r_ram_cnt;
        if (i_clr) begin
            w_ram_cnt_d = '0;
        end else if (w_push && !w_issue) begin
            w_ram_cnt_d = r_ram_cnt + 1'b1;
        end else if (!w_push && w_issue) begin
            w_ram_cnt_d = r_ram_cnt - 1'b1;
        end

        w_pf_cnt_d = w_pf_cnt;
        if (i_clr) begin
            w_pf_cnt_d = '0;
        end else if (w_fill && !w_pop) begin
            w_pf_cnt_d = w_pf_cnt + 1'b1;
        end else if (!w_fill && w_pop) begin
            w_pf_cnt_d = w_pf_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_flag    <= '0;
            r_drop    <= '0;
            r_count   <= '0;
        end else begin
            r_ram_cnt <= w_ram_cnt_d;
            r_flag    <= w_flag_d;
            r_drop    <= w_drop_d;
            r_count   <= CW'(w_ram_cnt_d) + CW'(w_inflight_d) + CW'(w_pf_cnt_d);
            if (i_clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    nx_ram_fifo_pf_buf #(
        .WIDTH (WIDTH),
        .DEPTH (PF_DEPTH)
    ) u_pf_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr),
        .i_wr    (w_fill),
        .i_wdata (i_ram_dout),
        .i_rd    (w_pop),
        .o_rdata (w_pf_data),
        .o_count (w_pf_cnt)
    );

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_data  = w_pf_data;
    assign o_count     = r_count;
    assign o_ram_web   = !w_push;
    assign o_ram_wa    = r_wr_ptr;
    assign o_ram_din   = i_in_data;
    assign o_ram_bwe   = '1;
    assign o_ram_reb   = !w_issue;
    assign o_ram_ra    = r_rd_ptr;

`ifndef SYNTHESIS
    a_params_legal: assert property (@(posedge i_clk)
        params_ok(DEPTH, RD_LATENCY, OUT_FLOP, PF_DEPTH));
    a_ram_idle_in_reset: assert property (@(posedge i_clk)
        !i_rst_n |-> (o_ram_web && o_ram_reb));
`endif

endmodule

// File: tb/tb_nx_ram_fifo_ctrl.sv
// Randomised bench for nx_ram_fifo_ctrl against a queue model of the FIFO contents.
module tb_nx_ram_fifo_ctrl;

    localparam int unsigned W        = 16;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned RD_LAT   = 2;
    localparam int unsigned OUT_FLOP = 1;
    localparam int unsigned L        = RD_LAT + OUT_FLOP;
    localparam int unsigned PF       = L + 1;
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = $clog2(DEPTH + PF + 1);

    logic          clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, out_valid, ram_web, ram_reb;
    logic [W-1:0]  out_data, ram_din, ram_bwe, ram_dout;
    logic [CW-1:0] count;
    logic [AW-1:0] ram_wa, ram_ra;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nx_ram_fifo_ctrl #(
        .WIDTH      (W),
        .DEPTH      (DEPTH),
        .RD_LATENCY (RD_LAT),
        .OUT_FLOP   (OUT_FLOP),
        .PF_DEPTH   (PF)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clr       (clr),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_count     (count),
        .o_ram_web   (ram_web),
        .o_ram_wa    (ram_wa),
        .o_ram_din   (ram_din),
        .o_ram_bwe   (ram_bwe),
        .o_ram_reb   (ram_reb),
        .o_ram_ra    (ram_ra),
        .i_ram_dout  (ram_dout)
    );

    // RAM macro: L-cycle read pipe, garbage when no read was issued.
    logic [W-1:0] mem  [DEPTH];
    logic [W-1:0] pipe [L];
    always @(posedge clk) begin
        if (!ram_web) mem[ram_wa] <= (ram_din & ram_bwe) | (mem[ram_wa] & ~ram_bwe);
        pipe[0] <= !ram_reb ? mem[ram_ra] : W'($urandom);
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign ram_dout = pipe[L-1];

    // Reference model: the words the FIFO holds, oldest first.
    logic [W-1:0]  mq[$];
    logic          s_ready, s_valid, s_web, s_reb, s_push, s_pop, had;
    logic [W-1:0]  s_head, exp_w;
    logic [AW-1:0] s_wa;
    logic [CW-1:0] s_cnt;

    task automatic step(input logic vin, input logic [W-1:0] din, input logic ordy,
                        input logic c);
        @(negedge clk);
        in_valid = vin; in_data = din; out_ready = ordy; clr = c;
        #1;
        s_ready = in_ready; s_valid = out_valid; s_web = ram_web; s_reb = ram_reb;
        s_head = out_data; s_wa = ram_wa;
        s_push = vin && s_ready;
        s_pop  = s_valid && ordy;
        @(posedge clk);
        #1;
        s_cnt = count;
    endtask

    task automatic model(input logic [W-1:0] din, input logic c);
        had = 1'b0; exp_w = '0;
        if (c) begin
            mq.delete();
            return;
        end
        if (s_pop && mq.size() > 0) begin
            had = 1'b1;
            exp_w = mq.pop_front();
        end
        if (s_push) mq.push_back(din);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (ram_web !== 1'b1) begin errors++; $display("FAIL rst_web got %b exp 1", ram_web); end
        checks++; if (ram_reb !== 1'b1) begin errors++; $display("FAIL rst_reb got %b exp 1", ram_reb); end
        checks++; if (count !== '0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
        mq.delete();
    endtask

    task automatic test_latency();
        int reb_cyc = -1;
        int val_cyc = -1;
        logic [W-1:0] vhead = '0;
        for (int c = 0; c < 10; c++) begin
            step(c == 0, W'(16'h00A5), 1'b0, 1'b0);
            model(W'(16'h00A5), 1'b0);
            if (c == 0) begin
                checks++; if (s_web !== 1'b0 || s_wa !== '0) begin
                    errors++; $display("FAIL lat_web got web=%b wa=%0d exp web=0 wa=0", s_web, s_wa);
                end
            end
            if (!s_reb && reb_cyc < 0) reb_cyc = c;
            if (s_valid && val_cyc < 0) begin val_cyc = c; vhead = s_head; end
            checks++; if (s_cnt !== CW'(mq.size())) begin
                errors++; $display("FAIL lat_count cyc %0d got %0d exp %0d", c + 1, s_cnt, mq.size());
            end
        end
        checks++; if (reb_cyc != 1) begin errors++; $display("FAIL lat_reb_cycle got %0d exp 1", reb_cyc); end
        checks++; if (val_cyc != int'(L) + 2) begin
            errors++; $display("FAIL lat_valid_cycle got %0d exp %0d", val_cyc, L + 2);
        end
        checks++; if (vhead !== W'(16'h00A5)) begin errors++; $display("FAIL lat_data got %h exp 00a5", vhead); end
        step(1'b0, '0, 1'b1, 1'b0);
        model('0, 1'b0);
        checks++; if (!s_pop || !had || s_head !== exp_w) begin
            errors++; $display("FAIL lat_pop got pop=%b data=%h exp pop=1 data=%h", s_pop, s_head, exp_w);
        end
        checks++; if (s_cnt !== CW'(mq.size())) begin errors++; $display("FAIL lat_drain_count got %0d exp %0d", s_cnt, mq.size()); end
    endtask

    task automatic test_fill();
        int acc = 0;
        logic [W-1:0] d;
        for (int c = 0; c < 40; c++) begin
            d = W'($urandom);
            step(1'b1, d, 1'b0, 1'b0);
            model(d, 1'b0);
            if (s_push) acc++;
            checks++; if (s_cnt !== CW'(mq.size())) begin
                errors++; $display("FAIL fill_count got %0d exp %0d", s_cnt, mq.size());
            end
        end
        checks++; if (acc != int'(DEPTH + PF)) begin errors++; $display("FAIL fill_accepted got %0d exp %0d", acc, DEPTH + PF); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", s_ready); end
        checks++; if (s_cnt !== CW'(DEPTH + PF)) begin errors++; $display("FAIL fill_full_count got %0d exp %0d", s_cnt, DEPTH + PF); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d;
        for (int c = 0; c < 80; c++) begin
            d = W'($urandom);
            step(c < 30, d, 1'b1, 1'b0);
            model(d, 1'b0);
            if (s_pop) begin
                checks++; if (!had || s_head !== exp_w) begin
                    errors++; $display("FAIL b2b_data got %h exp %h had %b", s_head, exp_w, had);
                end
            end
            checks++; if (s_cnt !== CW'(mq.size())) begin
                errors++; $display("FAIL b2b_count got %0d exp %0d", s_cnt, mq.size());
            end
        end
        checks++; if (mq.size() != 0) begin errors++; $display("FAIL b2b_drain left %0d exp 0", mq.size()); end
    endtask

    task automatic test_stream();
        int sent = 0, got = 0, gaps = 0;
        logic started = 1'b0;
        logic [W-1:0] d;
        for (int c = 0; c < 3000 && got < 1000; c++) begin
            d = W'(sent);
            step(sent < 1000, d, 1'b1, 1'b0);
            model(d, 1'b0);
            if (s_push) sent++;
            if (s_pop) begin
                got++;
                checks++; if (!had || s_head !== exp_w) begin
                    errors++; $display("FAIL stream_data got %h exp %h", s_head, exp_w);
                end
            end else if (started) begin
                gaps++;
            end
            if (s_valid) started = 1'b1;
            checks++; if (s_cnt !== CW'(mq.size())) begin
                errors++; $display("FAIL stream_count got %0d exp %0d", s_cnt, mq.size());
            end
        end
        checks++; if (got != 1000) begin errors++; $display("FAIL stream_words got %0d exp 1000", got); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps got %0d exp 0", gaps); end
    endtask

    task automatic test_clr();
        int reb_low = 0;
        int seen = 0;
        for (int c = 0; c < 4; c++) begin
            step(c < 2, W'(c + 1), 1'b0, c == 3);
            model(W'(c + 1), c == 3);
            if ((c == 1 || c == 2) && !s_reb) reb_low++;
        end
        checks++; if (reb_low != 2) begin errors++; $display("FAIL clr_setup got %0d reads exp 2", reb_low); end
        checks++; if (s_cnt !== '0) begin errors++; $display("FAIL clr_count got %0d exp 0", s_cnt); end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            model('0, 1'b0);
            checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL clr_stale_valid got %b exp 0", s_valid); end
        end
        for (int c = 0; c < 12 && seen == 0; c++) begin
            step(c == 0, W'(16'h0011), 1'b1, 1'b0);
            model(W'(16'h0011), 1'b0);
            if (s_pop) begin
                seen = 1;
                checks++; if (!had || s_head !== W'(16'h0011)) begin
                    errors++; $display("FAIL clr_first_data got %h exp 0011", s_head);
                end
            end
        end
        checks++; if (seen == 0) begin errors++; $display("FAIL clr_timeout got none exp 0011"); end
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic v, r, c;
        for (int n = 0; n < 640; n++) begin
            d = W'($urandom);
            v = (n < 600) && ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 2) != 0;
            c = (n < 600) && ($urandom_range(0, 63) == 0);
            if (n >= 600) r = 1'b1;
            step(v, d, r, c);
            model(d, c);
            if (s_pop) begin
                checks++; if (!had || s_head !== exp_w) begin
                    errors++; $display("FAIL rand_data got %h exp %h had %b", s_head, exp_w, had);
                end
            end
            checks++; if (s_cnt !== CW'(mq.size())) begin
                errors++; $display("FAIL rand_count got %0d exp %0d", s_cnt, mq.size());
            end
        end
    endtask

    task automatic test_async_reset();
        int seen = 0;
        for (int c = 0; c < 12; c++) begin
            step(1'b1, W'(c + 16'h0100), 1'b1, 1'b0);
            model(W'(c + 16'h0100), 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; #1;
        checks++; if (out_valid !== 1'b1 || ram_reb !== 1'b0) begin
            errors++; $display("FAIL arst_setup got valid=%b reb=%b exp 1 0", out_valid, ram_reb);
        end
        rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got %b exp 0", in_ready); end
        checks++; if (ram_web !== 1'b1 || ram_reb !== 1'b1) begin
            errors++; $display("FAIL arst_ram got web=%b reb=%b exp 1 1", ram_web, ram_reb);
        end
        checks++; if (count !== '0) begin errors++; $display("FAIL arst_count got %0d exp 0", count); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b1;
        mq.delete();
        for (int c = 0; c < 8; c++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            model('0, 1'b0);
            checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL arst_stale_valid got %b exp 0", s_valid); end
        end
        for (int c = 0; c < 12 && seen == 0; c++) begin
            step(c == 0, W'(16'h0077), 1'b1, 1'b0);
            model(W'(16'h0077), 1'b0);
            if (s_pop) begin
                seen = 1;
                checks++; if (!had || s_head !== W'(16'h0077)) begin
                    errors++; $display("FAIL arst_first_data got %h exp 0077", s_head);
                end
            end
        end
        checks++; if (seen == 0) begin errors++; $display("FAIL arst_timeout got none exp 0077"); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_back_to_back();
        test_stream();
        test_clr();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
